// File: rtl/dft_index_gen.sv
// dft_index_gen: index/address generator that sits after the DFT control FSM.
// It produces the sample index n, the bin index k and the twiddle index
// (n*k) mod N, and it returns the LOAD and COMP completion flags to the FSM.
// Optional build macro: DFT_IDX_HALF_SPECTRUM_EN. When it is defined, the bin
// loop stops at k = N>>1, because the other bins of a real-input transform
// are mirror images.
module dft_index_gen #(
  parameter int IDX_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [IDX_W-1:0] sample_num,
  input  logic             clear,
  input  logic             load_to_cache,
  input  logic             count_n_en,
  input  logic             count_k_en,
  output logic [IDX_W-1:0] n_idx,
  output logic [IDX_W-1:0] k_idx,
  output logic [IDX_W-1:0] tw_idx,
  output logic             idx_valid,
  output logic             bin_last,
  output logic             data_to_cache_loaded,
  output logic             calc_end
);

  logic [IDX_W-1:0] r_nLen;
  logic [IDX_W-1:0] r_nIdx;
  logic [IDX_W-1:0] r_kIdx;
  logic [IDX_W-1:0] r_twIdx;
  logic             r_clearD;
  logic             r_loaded;
  logic             r_calcEnd;

  logic             w_clrRise;
  logic             w_load;
  logic             w_comp;
  logic             w_lenZero;
  logic             w_nLast;
  logic             w_kLast;
  logic             w_issue;
  logic [IDX_W:0]   w_twSum;
  logic [IDX_W-1:0] w_twNext;

  assign w_clrRise = clear & ~r_clearD;
  assign w_load    = load_to_cache & count_n_en;
  assign w_comp    = ~load_to_cache & count_n_en & count_k_en;
  assign w_lenZero = (r_nLen == '0);
  assign w_nLast   = (r_nIdx == (r_nLen - IDX_W'(1)));

`ifdef DFT_IDX_HALF_SPECTRUM_EN
  assign w_kLast = (r_kIdx == (r_nLen >> 1));
`else
  assign w_kLast = (r_kIdx == (r_nLen - IDX_W'(1)));
`endif

  // The twiddle index moves forward by k on each inner step. The sum is one bit
  // wider so that a large N cannot overflow before the wrap.
  assign w_twSum  = {1'b0, r_twIdx} + {1'b0, r_kIdx};
  assign w_twNext = (w_twSum >= {1'b0, r_nLen}) ? IDX_W'(w_twSum - {1'b0, r_nLen})
                                                : IDX_W'(w_twSum);

  assign w_issue = ce & ~rst & ~w_clrRise & ~w_lenZero &
                   ((w_load & ~r_loaded) | (w_comp & ~r_calcEnd));

  assign n_idx                = r_nIdx;
  assign k_idx                = r_kIdx;
  assign tw_idx               = r_twIdx;
  assign idx_valid            = w_issue;
  assign bin_last             = w_issue & w_comp & w_nLast;
  assign data_to_cache_loaded = r_loaded;
  assign calc_end             = r_calcEnd;

  // Counter and flag update. A clear rising edge restarts everything.
  // Otherwise the counters advance once for each issued index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nLen    <= '0;
      r_nIdx    <= '0;
      r_kIdx    <= '0;
      r_twIdx   <= '0;
      r_clearD  <= 1'b0;
      r_loaded  <= 1'b0;
      r_calcEnd <= 1'b0;
    end else if (ce) begin
      r_clearD <= clear;
      if (w_clrRise) begin
        r_nLen    <= sample_num;
        r_nIdx    <= '0;
        r_kIdx    <= '0;
        r_twIdx   <= '0;
        r_loaded  <= 1'b0;
        r_calcEnd <= 1'b0;
      end else if (w_lenZero) begin
        if (w_load) begin
          r_loaded <= 1'b1;
        end else if (w_comp) begin
          r_calcEnd <= 1'b1;
        end
      end else if (w_issue) begin
        if (w_load) begin
          if (w_nLast) begin
            r_nIdx   <= '0;
            r_loaded <= 1'b1;
          end else begin
            r_nIdx <= r_nIdx + IDX_W'(1);
          end
        end else begin
          if (w_nLast) begin
            r_nIdx  <= '0;
            r_twIdx <= '0;
            if (w_kLast) begin
              r_kIdx    <= '0;
              r_calcEnd <= 1'b1;
            end else begin
              r_kIdx <= r_kIdx + IDX_W'(1);
            end
          end else begin
            r_nIdx  <= r_nIdx + IDX_W'(1);
            r_twIdx <= w_twNext;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dft_index_gen.sv
// tb_dft_index_gen: directed testbench for dft_index_gen.
// It applies hand-computed index sequences for the LOAD phase, the COMP phase,
// clock-enable gaps, a mid-phase restart and the degenerate N values.
module tb_dft_index_gen;

  localparam int IDX_W = 12;

  logic             clk;
  logic             rst;
  logic             ce;
  logic [IDX_W-1:0] sample_num;
  logic             clear;
  logic             load_to_cache;
  logic             count_n_en;
  logic             count_k_en;
  logic [IDX_W-1:0] n_idx;
  logic [IDX_W-1:0] k_idx;
  logic [IDX_W-1:0] tw_idx;
  logic             idx_valid;
  logic             bin_last;
  logic             data_to_cache_loaded;
  logic             calc_end;

  int total;
  int bad;

  dft_index_gen #(.IDX_W(IDX_W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ce                   (ce),
    .sample_num           (sample_num),
    .clear                (clear),
    .load_to_cache        (load_to_cache),
    .count_n_en           (count_n_en),
    .count_k_en           (count_k_en),
    .n_idx                (n_idx),
    .k_idx                (k_idx),
    .tw_idx               (tw_idx),
    .idx_valid            (idx_valid),
    .bin_last             (bin_last),
    .data_to_cache_loaded (data_to_cache_loaded),
    .calc_end             (calc_end)
  );

  // Free-running clock with a period of 10 time units.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Moves to just after the next rising edge, where new inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raises clear for one cycle with all enables off. The clear is then dropped.
  task automatic do_clear(input int n);
    sample_num    = IDX_W'(n);
    clear         = 1'b1;
    load_to_cache = 1'b0;
    count_n_en    = 1'b0;
    count_k_en    = 1'b0;
    ce            = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    for (int c = 0; c < 2; c++) begin
      clear         = (c == 0);
      load_to_cache = (c == 0);
      count_n_en    = 1'b1;
      count_k_en    = (c == 1);
      ce            = 1'b1;
      sample_num    = IDX_W'(5 + c);
      #4;
      total++;
      if (idx_valid !== 1'b0 || bin_last !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_valid: got valid=%b last=%b want 0 0", idx_valid, bin_last);
      end
      total++;
      if (n_idx !== '0 || k_idx !== '0 || tw_idx !== '0 ||
          data_to_cache_loaded !== 1'b0 || calc_end !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_state: got n=%0d k=%0d tw=%0d ld=%b ce=%b want all 0",
                 n_idx, k_idx, tw_idx, data_to_cache_loaded, calc_end);
      end
      tick();
    end
    rst = 1'b0; clear = 1'b0; load_to_cache = 1'b0;
    count_n_en = 1'b0; count_k_en = 1'b0;
    tick();
  endtask

  task automatic test_load();
    do_clear(4);
    load_to_cache = 1'b1;
    count_n_en    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #4;
      total++;
      if (idx_valid !== 1'b1 || n_idx !== IDX_W'(i) || k_idx !== '0 ||
          tw_idx !== '0 || data_to_cache_loaded !== 1'b0) begin
        bad++;
        $display("[TB] FAIL load_issue%0d: got v=%b n=%0d k=%0d tw=%0d ld=%b want v=1 n=%0d k=0 tw=0 ld=0",
                 i, idx_valid, n_idx, k_idx, tw_idx, data_to_cache_loaded, i);
      end
      tick();
    end
    #4;
    total++;
    if (data_to_cache_loaded !== 1'b1 || idx_valid !== 1'b0 || n_idx !== '0) begin
      bad++;
      $display("[TB] FAIL load_done: got ld=%b v=%b n=%0d want ld=1 v=0 n=0",
               data_to_cache_loaded, idx_valid, n_idx);
    end
    tick();
    load_to_cache = 1'b0;
    count_n_en    = 1'b0;
    #4;
    total++;
    if (data_to_cache_loaded !== 1'b1 || idx_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL load_sticky: got ld=%b v=%b want ld=1 v=0", data_to_cache_loaded, idx_valid);
    end
    tick();
  endtask

  task automatic test_comp();
    int expTw[9] = '{0, 0, 0, 0, 1, 2, 0, 2, 1};
    do_clear(3);
    count_n_en = 1'b1;
    count_k_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #4;
      total++;
      if (idx_valid !== 1'b1 || n_idx !== IDX_W'(i % 3) || k_idx !== IDX_W'(i / 3) ||
          tw_idx !== IDX_W'(expTw[i]) || bin_last !== (i % 3 == 2) || calc_end !== 1'b0) begin
        bad++;
        $display("[TB] FAIL comp_issue%0d: got v=%b n=%0d k=%0d tw=%0d bl=%b end=%b want v=1 n=%0d k=%0d tw=%0d bl=%0d end=0",
                 i, idx_valid, n_idx, k_idx, tw_idx, bin_last, calc_end,
                 i % 3, i / 3, expTw[i], (i % 3 == 2));
      end
      tick();
    end
    #4;
    total++;
    if (calc_end !== 1'b1 || idx_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL comp_done: got end=%b v=%b want end=1 v=0", calc_end, idx_valid);
    end
    tick();
  endtask

  task automatic test_ce_toggle();
    int expTw[9] = '{0, 0, 0, 0, 1, 2, 0, 2, 1};
    int i = 0;
    do_clear(3);
    #4;
    total++;
    if (calc_end !== 1'b0) begin
      bad++;
      $display("[TB] FAIL clear_flag: got end=%b want 0", calc_end);
    end
    tick();
    count_n_en = 1'b1;
    count_k_en = 1'b1;
    for (int cyc = 0; cyc < 40 && i < 9; cyc++) begin
      ce = (cyc % 2 == 0);
      #4;
      total++;
      if (ce) begin
        if (idx_valid !== 1'b1 || n_idx !== IDX_W'(i % 3) || k_idx !== IDX_W'(i / 3) ||
            tw_idx !== IDX_W'(expTw[i]) || bin_last !== (i % 3 == 2)) begin
          bad++;
          $display("[TB] FAIL ce_issue%0d: got v=%b n=%0d k=%0d tw=%0d bl=%b want v=1 n=%0d k=%0d tw=%0d bl=%0d",
                   i, idx_valid, n_idx, k_idx, tw_idx, bin_last,
                   i % 3, i / 3, expTw[i], (i % 3 == 2));
        end
        i++;
      end else begin
        if (idx_valid !== 1'b0 || n_idx !== IDX_W'(i % 3) || calc_end !== (i == 9)) begin
          bad++;
          $display("[TB] FAIL ce_hold%0d: got v=%b n=%0d end=%b want v=0 n=%0d end=%0d",
                   cyc, idx_valid, n_idx, calc_end, i % 3, (i == 9));
        end
      end
      tick();
    end
    ce = 1'b1;
    #4;
    total++;
    if (i != 9 || calc_end !== 1'b1 || idx_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ce_done: got issues=%0d end=%b v=%b want issues=9 end=1 v=0", i, calc_end, idx_valid);
    end
    tick();
  endtask

  task automatic test_midclear();
    int expTw[4] = '{0, 0, 0, 1};
    do_clear(3);
    count_n_en = 1'b1;
    count_k_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    sample_num = IDX_W'(2);
    clear      = 1'b1;
    #4;
    total++;
    if (idx_valid !== 1'b0 || n_idx !== IDX_W'(2) || k_idx !== IDX_W'(1)) begin
      bad++;
      $display("[TB] FAIL midclr_edge: got v=%b n=%0d k=%0d want v=0 n=2 k=1", idx_valid, n_idx, k_idx);
    end
    tick();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #4;
      total++;
      if (idx_valid !== 1'b1 || n_idx !== IDX_W'(i % 2) || k_idx !== IDX_W'(i / 2) ||
          tw_idx !== IDX_W'(expTw[i]) || bin_last !== (i % 2 == 1) || calc_end !== 1'b0) begin
        bad++;
        $display("[TB] FAIL midclr_issue%0d: got v=%b n=%0d k=%0d tw=%0d bl=%b end=%b want v=1 n=%0d k=%0d tw=%0d bl=%0d end=0",
                 i, idx_valid, n_idx, k_idx, tw_idx, bin_last, calc_end,
                 i % 2, i / 2, expTw[i], (i % 2 == 1));
      end
      tick();
    end
    #4;
    total++;
    if (calc_end !== 1'b1 || idx_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midclr_done: got end=%b v=%b want end=1 v=0", calc_end, idx_valid);
    end
    tick();
  endtask

  task automatic test_n_zero();
    do_clear(0);
    load_to_cache = 1'b1;
    count_n_en    = 1'b1;
    #4;
    total++;
    if (idx_valid !== 1'b0 || data_to_cache_loaded !== 1'b0) begin
      bad++;
      $display("[TB] FAIL zero_load_first: got v=%b ld=%b want v=0 ld=0", idx_valid, data_to_cache_loaded);
    end
    tick();
    load_to_cache = 1'b0;
    count_k_en    = 1'b1;
    #4;
    total++;
    if (idx_valid !== 1'b0 || data_to_cache_loaded !== 1'b1 || calc_end !== 1'b0) begin
      bad++;
      $display("[TB] FAIL zero_load_done: got v=%b ld=%b end=%b want v=0 ld=1 end=0",
               idx_valid, data_to_cache_loaded, calc_end);
    end
    tick();
    #4;
    total++;
    if (idx_valid !== 1'b0 || calc_end !== 1'b1) begin
      bad++;
      $display("[TB] FAIL zero_comp_done: got v=%b end=%b want v=0 end=1", idx_valid, calc_end);
    end
    tick();
  endtask

  task automatic test_n_one();
    do_clear(1);
    count_n_en = 1'b1;
    count_k_en = 1'b1;
    #4;
    total++;
    if (idx_valid !== 1'b1 || bin_last !== 1'b1 || n_idx !== '0 || k_idx !== '0 || tw_idx !== '0) begin
      bad++;
      $display("[TB] FAIL one_issue: got v=%b bl=%b n=%0d k=%0d tw=%0d want v=1 bl=1 n=0 k=0 tw=0",
               idx_valid, bin_last, n_idx, k_idx, tw_idx);
    end
    tick();
    #4;
    total++;
    if (idx_valid !== 1'b0 || calc_end !== 1'b1) begin
      bad++;
      $display("[TB] FAIL one_done: got v=%b end=%b want v=0 end=1", idx_valid, calc_end);
    end
    tick();
  endtask

  task automatic test_n_four();
`ifdef DFT_IDX_HALF_SPECTRUM_EN
    int kCount = 3;
`else
    int kCount = 4;
`endif
    do_clear(4);
    count_n_en = 1'b1;
    count_k_en = 1'b1;
    for (int i = 0; i < kCount * 4; i++) begin
      #4;
      total++;
      if (idx_valid !== 1'b1 || n_idx !== IDX_W'(i % 4) || k_idx !== IDX_W'(i / 4) ||
          tw_idx !== IDX_W'(((i % 4) * (i / 4)) % 4) || calc_end !== 1'b0) begin
        bad++;
        $display("[TB] FAIL n4_issue%0d: got v=%b n=%0d k=%0d tw=%0d end=%b want v=1 n=%0d k=%0d tw=%0d end=0",
                 i, idx_valid, n_idx, k_idx, tw_idx, calc_end,
                 i % 4, i / 4, ((i % 4) * (i / 4)) % 4);
      end
      tick();
    end
    #4;
    total++;
    if (calc_end !== 1'b1 || idx_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL n4_done: got end=%b v=%b want end=1 v=0", calc_end, idx_valid);
    end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst           = 1'b1;
    ce            = 1'b0;
    sample_num    = '0;
    clear         = 1'b0;
    load_to_cache = 1'b0;
    count_n_en    = 1'b0;
    count_k_en    = 1'b0;
    #1;
    test_reset();
    test_load();
    test_comp();
    test_ce_toggle();
    test_midclear();
    test_n_zero();
    test_n_one();
    test_n_four();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dft_index_gen.md
Name: dft_index_gen

Overview:
- Index/address generator directly downstream of the DFT control FSM.
- Consumes the FSM strobes: clear, load_to_cache, count_n_en, count_k_en.
- Produces per cycle:
  - the sample index n
  - the bin index k
  - the twiddle index (n*k) mod N
- Returns the phase-completion flags data_to_cache_loaded and calc_end to the FSM.

Parameters:
- IDX_W, 12: width of sample_num and of all index outputs. N max = 2^IDX_W - 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- ce  in  1  clock enable; when 0, all state holds and idx_valid=0.
- sample_num  in  IDX_W  transform length N; latched on the clear rising edge.
- clear  in  1  FSM clear strobe; only its rising edge is used.
- load_to_cache  in  1  selects LOAD phase (sample copy into cache).
- count_n_en  in  1  n-counter enable from FSM.
- count_k_en  in  1  k-counter enable from FSM.
- n_idx  out  IDX_W  current sample index.
- k_idx  out  IDX_W  current bin index.
- tw_idx  out  IDX_W  (n_idx*k_idx) mod N_r.
- idx_valid  out  1  indices on n/k/tw are issued this cycle.
- bin_last  out  1  idx_valid term is last term of bin k_idx (COMP only).
- data_to_cache_loaded  out  1  sticky: LOAD phase complete.
- calc_end  out  1  sticky: COMP phase complete.

Behaviour:
- Reset (rst=1 at clk edge): n_idx=k_idx=tw_idx=0, N_r=0, clear_d=0, data_to_cache_loaded=0, calc_end=0. idx_valid and bin_last are 0 while rst=1.
- Clear edge detect: clr_rise = clear & ~clear_d. clear_d is updated only when ce=1.
- On a clr_rise cycle (with ce=1):
  - N_r<=sample_num; n_idx<=0; k_idx<=0; tw_idx<=0.
  - Both sticky flags cleared.
  - No index issued that cycle.
  - Also restarts any operation in progress (mid-phase clear = full restart).
- Phase decode (combinational, when not clr_rise):
  - LOAD = load_to_cache & count_n_en.
  - COMP = ~load_to_cache & count_n_en & count_k_en.
  - LOAD has priority if load_to_cache=1. Otherwise the block holds.
- Issue rule (both combinational):
  - idx_valid = ce & ~rst & ~clr_rise & N_r!=0 & ((LOAD & ~data_to_cache_loaded) | (COMP & ~calc_end)).
  - bin_last = idx_valid & COMP & n_idx==N_r-1.
- Counter update happens at the edge of each idx_valid cycle; registered outputs show the next index on the following cycle.
- LOAD phase: k_idx and tw_idx hold at 0.
  - n_idx increments 0..N_r-1.
  - When n_idx==N_r-1 is issued: data_to_cache_loaded<=1 and n_idx<=0.
- COMP phase: n is the inner loop, k the outer loop.
  - On issue with n_idx<N_r-1: n_idx+1; tw_idx<=tw_idx+k_idx, minus N_r if the sum >=N_r. Compute the sum at IDX_W+1 bits, no overflow.
  - On issue with n_idx==N_r-1: n_idx<=0, tw_idx<=0.
    - If k_idx<N_r-1: k_idx+1.
    - Else: calc_end<=1 and k_idx<=0.
  - Exactly N_r*N_r issues per COMP phase.
- N_r==0: no indices are issued. On the first cycle with ce & LOAD, data_to_cache_loaded<=1. On the first cycle with ce & COMP, calc_end<=1.
- N_r==1: one issue per phase (n=k=tw=0); bin_last=1 on the COMP issue.
- Sticky flags stay high until rst or the next clr_rise, even if the enables drop.
- ce=0 mid-phase: indices and flags frozen; issuing resumes seamlessly when ce returns to 1.
- Enables dropping mid-phase: counters hold their position; issuing resumes from there when the enables return.
- Latency: an index is valid in the same cycle idx_valid is asserted. A done flag is visible 1 cycle after the last issue.

Optional Feature:
- Macro: DFT_IDX_HALF_SPECTRUM_EN (for real-input symmetry).
- Defined: the COMP outer loop stops at k_idx==N_r>>1. calc_end is set when n_idx==N_r-1 is issued with k_idx==N_r>>1, giving N_r*((N_r>>1)+1) issues.
- Not defined: the full k range 0..N_r-1, as specified above.
- LOAD phase is identical in both builds.

Test Plan:
- rst=1 for 2 cycles with all inputs toggling -> all outputs 0, idx_valid=0 throughout.
- sample_num=4, clear rise, then load_to_cache=count_n_en=1 (ce=1) -> n_idx 0,1,2,3 with idx_valid on 4 consecutive cycles; data_to_cache_loaded=1 the next cycle; idx_valid=0 afterwards.
- sample_num=3, clear rise, COMP (count_n_en=count_k_en=1, load_to_cache=0):
  - tw_idx sequence 0,0,0 | 0,1,2 | 0,2,1 for k=0,1,2.
  - bin_last on issues 3, 6, 9.
  - calc_end=1 after the 9th issue.
- Same N=3 COMP with ce toggled 1,0,1,0... -> identical index sequence, issued only on ce=1 cycles; calc_end after 9 ce-high issues.
- Mid-COMP (k=1,n=2) clear rise with sample_num=2 -> next issue is n=k=tw=0; calc_end cleared and re-set after 4 issues.
- sample_num=0, clear rise, LOAD -> no idx_valid; data_to_cache_loaded=1 after the first ce cycle.
- With DFT_IDX_HALF_SPECTRUM_EN, N=4 -> k_idx runs 0..2; calc_end after 12 issues.
